// File: rtl/comp_beat_packer.sv
// Packs LSB-aligned variable-length codewords into DATA_W-bit beats for the memory
// controller and reports the remaining pad-beat count to the zero-pad generator.
module comp_beat_packer #(
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 7,
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              last_i,
  output logic              beat_valid_o,
  output logic [DATA_W-1:0] beat_o,
  input  logic              ready_i,
  output logic              eop_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  comp_size_o,
  input  logic              pad_done_i,
  output logic              overflow_o
);

  localparam int ACC_W   = 2 * DATA_W;
  localparam int FILL_W  = 8;
  localparam int BEATS_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_EOP   = 2'd2,
    ST_PAD   = 2'd3
  } state_t;

  // Keeps only the low len bits of a codeword so stale upper bits never leak into a beat.
  function automatic logic [DATA_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  state_t              state_r, state_s;
  logic [ACC_W-1:0]    buf_r, buf_s;
  logic [FILL_W-1:0]   fill_r, fill_s;
  logic [BEATS_W-1:0]  beats_r, beats_s;
  logic                ovf_r, ovf_s;

  logic                ready_r;
  logic                beat_valid_r;
  logic [DATA_W-1:0]   beat_r;
  logic                eop_r;
  logic                done_r;
  logic [CNT_W-1:0]    comp_size_r;
  logic                overflow_r;

  logic                accept_s;
  logic                beat_fire_s;
  logic                bv_s;
  logic                capture_s;
  logic [BEATS_W-1:0]  cs_full_s;

  // ready_r mirrors (state==ACC && fill<DATA_W), so it doubles as the accept qualifier.
  assign accept_s    = valid_i & ready_r;
  assign beat_fire_s = beat_valid_r & ready_i;

  // Next-state for the accumulator, beat counter and block FSM.
  always_comb begin
    state_s = state_r;
    buf_s   = buf_r;
    fill_s  = fill_r;
    beats_s = beats_r;
    ovf_s   = ovf_r;

    // Accept and beat handshake are mutually exclusive: one needs fill<64, the other fill>=64 or FLUSH.
    if (beat_fire_s) begin
      buf_s  = buf_r >> DATA_W;
      fill_s = (fill_r >= FILL_W'(DATA_W)) ? (fill_r - FILL_W'(DATA_W)) : '0;
      if (beats_r == BEATS_W'(MAX_BEATS)) begin
        ovf_s = 1'b1;
      end else begin
        beats_s = beats_r + BEATS_W'(1);
      end
    end else if (accept_s) begin
      buf_s  = buf_r | (ACC_W'(data_i & len_mask(len_i)) << fill_r);
      fill_s = fill_r + FILL_W'(len_i);
    end else begin
      buf_s  = buf_r;
      fill_s = fill_r;
    end

    case (state_r)
      ST_ACC: begin
        if (accept_s && last_i) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = ST_ACC;
        end
      end
      ST_FLUSH: begin
        if (fill_s == '0) begin
          state_s = ST_EOP;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_EOP: begin
        beats_s = '0;
        ovf_s   = 1'b0;
        if (comp_size_r == '0) begin
          state_s = ST_ACC;
        end else begin
          state_s = ST_PAD;
        end
      end
      ST_PAD: begin
        if (pad_done_i) begin
          state_s = ST_ACC;
        end else begin
          state_s = ST_PAD;
        end
      end
      default: begin
        state_s = ST_ACC;
      end
    endcase
  end

  // Output predicates evaluated on next-state values so every output can be registered.
  always_comb begin
    bv_s      = 1'b0;
    capture_s = (state_s == ST_EOP) && (state_r != ST_EOP);
    cs_full_s = BEATS_W'(MAX_BEATS) - beats_s;
    if (((state_s == ST_ACC) || (state_s == ST_FLUSH)) && (fill_s >= FILL_W'(DATA_W))) begin
      bv_s = 1'b1;
    end else if ((state_s == ST_FLUSH) && (fill_s != '0)) begin
      bv_s = 1'b1;
    end else begin
      bv_s = 1'b0;
    end
  end

  // State, accumulator and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_ACC;
      buf_r        <= '0;
      fill_r       <= '0;
      beats_r      <= '0;
      ovf_r        <= 1'b0;
      ready_r      <= 1'b1;
      beat_valid_r <= 1'b0;
      beat_r       <= '0;
      eop_r        <= 1'b0;
      done_r       <= 1'b0;
      comp_size_r  <= '0;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      buf_r        <= buf_s;
      fill_r       <= fill_s;
      beats_r      <= beats_s;
      ovf_r        <= ovf_s;
      ready_r      <= (state_s == ST_ACC) && (fill_s < FILL_W'(DATA_W));
      beat_valid_r <= bv_s;
      beat_r       <= bv_s ? buf_s[DATA_W-1:0] : '0;
      eop_r        <= (state_s == ST_EOP);
      done_r       <= (state_s == ST_EOP) || (state_s == ST_PAD);
      // A full or overfull line wraps to 0 pad beats; held until the next block end.
      if (capture_s) begin
        comp_size_r <= cs_full_s[CNT_W-1:0];
        overflow_r  <= ovf_s;
      end else begin
        comp_size_r <= comp_size_r;
        overflow_r  <= overflow_r;
      end
    end
  end

  assign ready_o      = ready_r;
  assign beat_valid_o = beat_valid_r;
  assign beat_o       = beat_r;
  assign eop_o        = eop_r;
  assign done_o       = done_r;
  assign comp_size_o  = comp_size_r;
  assign overflow_o   = overflow_r;

endmodule

// File: tb/tb_comp_beat_packer.sv
// Self-checking bench for comp_beat_packer: a bit-queue model of the codeword stream
// predicts beats, pad count and overflow for directed and randomized blocks.
module tb_comp_beat_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [63:0] data_i = 64'd0;
  logic [6:0]  len_i = 7'd0;
  logic        last_i = 1'b0;
  logic        beat_valid_o;
  logic [63:0] beat_o;
  logic        ready_i = 1'b1;
  logic        eop_o;
  logic        done_o;
  logic [2:0]  comp_size_o;
  logic        pad_done_i = 1'b0;
  logic        overflow_o;

  int tests = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  logic [63:0] got_beats[$];
  logic [63:0] exp_beats[$];
  bit          model_bits[$];
  int          eop_count = 0;

  bit          seen_eop;
  logic [2:0]  eop_cs;
  logic        eop_ovf;
  logic        eop_done;

  always #5 clk = ~clk;

  comp_beat_packer dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .len_i(len_i), .last_i(last_i),
    .beat_valid_o(beat_valid_o), .beat_o(beat_o), .ready_i(ready_i),
    .eop_o(eop_o), .done_o(done_o), .comp_size_o(comp_size_o),
    .pad_done_i(pad_done_i), .overflow_o(overflow_o)
  );

  // Beats are collected where the handshake is decided, half a cycle before the edge.
  always @(negedge clk) begin
    if (rst_n && beat_valid_o && ready_i) got_beats.push_back(beat_o);
    if (eop_o) eop_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_push(input logic [63:0] d, input int l);
    for (int i = 0; i < l; i++) model_bits.push_back(d[i]);
  endtask

  task automatic model_build();
    logic [63:0] b;
    exp_beats.delete();
    while (model_bits.size() > 0) begin
      b = 64'd0;
      for (int i = 0; i < 64 && model_bits.size() > 0; i++) b[i] = model_bits.pop_front();
      exp_beats.push_back(b);
    end
  endtask

  function automatic logic [2:0] model_cs();
    int nb = exp_beats.size();
    return (nb >= 8) ? 3'd0 : 3'((8 - nb) % 8);
  endfunction

  task automatic send_cw(input logic [63:0] d, input int l, input bit lst);
    int n = 0;
    model_push(d, l);
    valid_i = 1'b1; data_i = d; len_i = l[6:0]; last_i = lst;
    while (!ready_o && n < 500) begin tick(); n++; end
    if (!ready_o) begin
      tests++; errors++;
      $display("FAIL send_cw: ready_o stayed %b for %0d cycles, required 1", ready_o, n);
    end else begin
      tick();
    end
    valid_i = 1'b0; last_i = 1'b0; data_i = {$urandom(), $urandom()};
  endtask

  task automatic wait_eop(input int bound);
    int n = 0;
    seen_eop = 1'b0;
    while (!eop_o && n < bound) begin tick(); n++; end
    if (eop_o) begin
      seen_eop = 1'b1; eop_cs = comp_size_o; eop_ovf = overflow_o; eop_done = done_o;
    end
  endtask

  task automatic release_pad();
    rand_ready = 1'b0; ready_i = 1'b1;
    tick();
    if (done_o) begin
      pad_done_i = 1'b1; tick(); pad_done_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    tests++; if (beat_valid_o !== 1'b0) begin errors++; $display("FAIL reset_beat_valid: got %b want 0", beat_valid_o); end
    tests++; if (beat_o !== 64'd0) begin errors++; $display("FAIL reset_beat: got %h want 0", beat_o); end
    tests++; if ({eop_o, done_o, overflow_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: eop/done/ovf got %b want 000", {eop_o, done_o, overflow_o}); end
    tests++; if (comp_size_o !== 3'd0) begin errors++; $display("FAIL reset_comp_size: got %0d want 0", comp_size_o); end
  endtask

  task automatic test_full_beats();
    int b0 = got_beats.size();
    int e0 = eop_count;
    model_bits.delete(); ready_i = 1'b1;
    for (int i = 0; i < 8; i++) send_cw(64'(i), 64, (i == 7));
    model_build();
    wait_eop(200);
    tests++; if (seen_eop !== 1'b1) begin errors++; $display("FAIL t1_eop: got %b want 1", seen_eop); end
    tests++; if (got_beats.size() - b0 != 8) begin errors++; $display("FAIL t1_beat_count: got %0d want 8", got_beats.size() - b0); end
    for (int k = 0; k < 8 && b0 + k < got_beats.size(); k++) begin
      tests++; if (got_beats[b0+k] !== exp_beats[k]) begin errors++; $display("FAIL t1_beat%0d: got %h want %h", k, got_beats[b0+k], exp_beats[k]); end
    end
    tests++; if ({eop_cs, eop_ovf} !== 4'b0000) begin errors++; $display("FAIL t1_size_ovf: got cs=%0d ovf=%b want cs=0 ovf=0", eop_cs, eop_ovf); end
    tick();
    tests++; if ({done_o, ready_o} !== 2'b01) begin errors++; $display("FAIL t1_no_pad: done/ready got %b want 01", {done_o, ready_o}); end
    tests++; if (eop_count - e0 != 1) begin errors++; $display("FAIL t1_eop_pulses: got %0d want 1", eop_count - e0); end
  endtask

  task automatic test_partial_pad();
    logic [19:0] vals [3] = '{20'hABCDE, 20'h12345, 20'hFFFFF};
    logic [63:0] d;
    int b0 = got_beats.size();
    model_bits.delete(); ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = {$urandom(), $urandom()};
      d[19:0] = vals[i];
      send_cw(d, 20, (i == 2));
    end
    model_build();
    wait_eop(200);
    tests++; if (got_beats.size() - b0 != 1) begin errors++; $display("FAIL t2_beat_count: got %0d want 1", got_beats.size() - b0); end
    if (got_beats.size() > b0) begin
      tests++; if (got_beats[b0] !== 64'h0FFF_FF12_345A_BCDE) begin errors++; $display("FAIL t2_beat: got %h want 0fffff12345abcde", got_beats[b0]); end
    end
    tests++; if ({seen_eop, eop_done, eop_cs, eop_ovf} !== {1'b1, 1'b1, 3'd7, 1'b0}) begin
      errors++; $display("FAIL t2_eop: seen=%b done=%b cs=%0d ovf=%b want 1 1 7 0", seen_eop, eop_done, eop_cs, eop_ovf);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if ({done_o, ready_o, beat_valid_o, eop_o} !== 4'b1000) begin errors++; $display("FAIL t2_pad_hold%0d: done/ready/bv/eop got %b want 1000", i, {done_o, ready_o, beat_valid_o, eop_o}); end
    end
    pad_done_i = 1'b1; tick(); pad_done_i = 1'b0;
    tests++; if ({done_o, ready_o} !== 2'b01) begin errors++; $display("FAIL t2_pad_exit: done/ready got %b want 01", {done_o, ready_o}); end
  endtask

  task automatic test_stall();
    logic [63:0] c0 = {$urandom(), $urandom()};
    logic [63:0] c1 = {$urandom(), $urandom()};
    logic [63:0] want0;
    int b0 = got_beats.size();
    model_bits.delete(); ready_i = 1'b0;
    send_cw(c0, 40, 1'b0);
    send_cw(c1, 40, 1'b1);
    model_build();
    want0 = {c1[23:0], c0[39:0]};
    for (int i = 0; i < 5; i++) begin
      tests++; if ({beat_valid_o, ready_o} !== 2'b10 || beat_o !== want0) begin
        errors++; $display("FAIL t3_stall%0d: bv/ready=%b beat=%h want 10 %h", i, {beat_valid_o, ready_o}, beat_o, want0);
      end
      tick();
    end
    ready_i = 1'b1;
    wait_eop(200);
    tests++; if (got_beats.size() - b0 != 2) begin errors++; $display("FAIL t3_beat_count: got %0d want 2", got_beats.size() - b0); end
    for (int k = 0; k < exp_beats.size() && b0 + k < got_beats.size(); k++) begin
      tests++; if (got_beats[b0+k] !== exp_beats[k]) begin errors++; $display("FAIL t3_beat%0d: got %h want %h", k, got_beats[b0+k], exp_beats[k]); end
    end
    tests++; if (eop_cs !== 3'd6) begin errors++; $display("FAIL t3_comp_size: got %0d want 6", eop_cs); end
    release_pad();
  endtask

  task automatic test_overflow();
    int b0 = got_beats.size();
    model_bits.delete(); ready_i = 1'b1;
    for (int i = 0; i < 9; i++) send_cw({$urandom(), $urandom()}, 64, (i == 8));
    model_build();
    wait_eop(300);
    tests++; if (got_beats.size() - b0 != 9) begin errors++; $display("FAIL t4_beat_count: got %0d want 9", got_beats.size() - b0); end
    for (int k = 0; k < exp_beats.size() && b0 + k < got_beats.size(); k++) begin
      tests++; if (got_beats[b0+k] !== exp_beats[k]) begin errors++; $display("FAIL t4_beat%0d: got %h want %h", k, got_beats[b0+k], exp_beats[k]); end
    end
    tests++; if ({seen_eop, eop_ovf, eop_cs} !== {1'b1, 1'b1, 3'd0}) begin errors++; $display("FAIL t4_eop: seen=%b ovf=%b cs=%0d want 1 1 0", seen_eop, eop_ovf, eop_cs); end
    release_pad();
    tests++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL t4_ovf_held: got %b want 1", overflow_o); end
  endtask

  task automatic test_zero_block();
    int b0 = got_beats.size();
    model_bits.delete(); ready_i = 1'b1;
    send_cw({$urandom(), $urandom()}, 0, 1'b1);
    wait_eop(50);
    tests++; if ({seen_eop, eop_ovf, eop_cs} !== {1'b1, 1'b0, 3'd0}) begin errors++; $display("FAIL zero_eop: seen=%b ovf=%b cs=%0d want 1 0 0", seen_eop, eop_ovf, eop_cs); end
    tests++; if (got_beats.size() != b0) begin errors++; $display("FAIL zero_beats: got %0d want 0", got_beats.size() - b0); end
    release_pad();
  endtask

  task automatic test_reset_mid();
    logic [63:0] d = {$urandom(), $urandom()};
    int b0;
    model_bits.delete(); ready_i = 1'b0;
    send_cw({$urandom(), $urandom()}, 60, 1'b0);
    send_cw({$urandom(), $urandom()}, 40, 1'b1);
    tick();
    tests++; if (beat_valid_o !== 1'b1) begin errors++; $display("FAIL t5_pending: bv got %b want 1", beat_valid_o); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    tests++; if ({beat_valid_o, eop_o, ready_o, done_o} !== 4'b0010) begin errors++; $display("FAIL t5_after_reset: bv/eop/ready/done got %b want 0010", {beat_valid_o, eop_o, ready_o, done_o}); end
    model_bits.delete(); ready_i = 1'b1;
    b0 = got_beats.size();
    send_cw(d, 8, 1'b1);
    model_build();
    wait_eop(50);
    tests++; if (got_beats.size() - b0 != 1) begin errors++; $display("FAIL t5_beat_count: got %0d want 1", got_beats.size() - b0); end
    if (got_beats.size() > b0) begin
      tests++; if (got_beats[b0] !== {56'd0, d[7:0]}) begin errors++; $display("FAIL t5_beat: got %h want %h", got_beats[b0], {56'd0, d[7:0]}); end
    end
    tests++; if (eop_cs !== 3'd7) begin errors++; $display("FAIL t5_comp_size: got %0d want 7", eop_cs); end
    release_pad();
  endtask

  task automatic test_pad_done_in_acc();
    int e0 = eop_count;
    ready_i = 1'b1;
    pad_done_i = 1'b1; tick(); pad_done_i = 1'b0;
    tick();
    tests++; if ({ready_o, done_o, beat_valid_o} !== 3'b100) begin errors++; $display("FAIL t6_acc_ignore: ready/done/bv got %b want 100", {ready_o, done_o, beat_valid_o}); end
    tests++; if (eop_count != e0) begin errors++; $display("FAIL t6_no_eop: got %0d pulses want 0", eop_count - e0); end
  endtask

  task automatic test_random();
    int b0, n, l;
    for (int blk = 0; blk < 6; blk++) begin
      model_bits.delete();
      b0 = got_beats.size();
      rand_ready = 1'b1;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        l = ($urandom_range(0, 3) == 0) ? 64 : $urandom_range(0, 64);
        send_cw({$urandom(), $urandom()}, l, (i == n - 1));
      end
      model_build();
      wait_eop(2000);
      tests++; if (seen_eop !== 1'b1) begin errors++; $display("FAIL rnd%0d_eop: got %b want 1", blk, seen_eop); end
      tests++; if (got_beats.size() - b0 != exp_beats.size()) begin errors++; $display("FAIL rnd%0d_beat_count: got %0d want %0d", blk, got_beats.size() - b0, exp_beats.size()); end
      for (int k = 0; k < exp_beats.size() && b0 + k < got_beats.size(); k++) begin
        tests++; if (got_beats[b0+k] !== exp_beats[k]) begin errors++; $display("FAIL rnd%0d_beat%0d: got %h want %h", blk, k, got_beats[b0+k], exp_beats[k]); end
      end
      tests++; if (eop_cs !== model_cs() || eop_ovf !== (exp_beats.size() > 8)) begin
        errors++; $display("FAIL rnd%0d_size_ovf: got cs=%0d ovf=%b want cs=%0d ovf=%b", blk, eop_cs, eop_ovf, model_cs(), (exp_beats.size() > 8));
      end
      release_pad();
    end
  endtask

  initial begin
    test_reset();
    test_full_beats();
    test_partial_pad();
    test_stall();
    test_overflow();
    test_zero_block();
    test_reset_mid();
    test_pad_done_in_acc();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
